// File: rtl/strfmt_pkg.sv
// rtl/strfmt_pkg.sv - shared types and ASCII constants for the strfmt conversion engine
package strfmt_pkg;

  typedef enum logic [1:0] {
    RADIX_DEC = 2'b00,
    RADIX_HEX = 2'b01,
    RADIX_OCT = 2'b10,
    RADIX_BIN = 2'b11
  } radix_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CONV = 2'b01,
    ST_EMIT = 2'b10
  } state_e;

  localparam int BUF_DEPTH = 33;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d < 4'd10) ? (ASCII_0 + {4'd0, d}) : (ASCII_LA + {4'd0, d} - 8'd10);
  endfunction

endpackage

// File: rtl/strfmt_rr_arb.sv
// rtl/strfmt_rr_arb.sv - combinational round-robin grant: first valid index at or after ptr_i
module strfmt_rr_arb
  import strfmt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  logic [ID_W-1:0] j;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    j           = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = ID_W'((int'(ptr_i) + i) % NREQ);
      if (!gnt_valid_o && req_i[j]) begin
        gnt_valid_o = 1'b1;
        gnt_o[j]    = 1'b1;
        gnt_idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/strfmt_scheduler.sv
// rtl/strfmt_scheduler.sv - arbitrated number-to-ASCII converter streaming MSB-first
// Optional decimal support is enabled by defining STRFMT_DEC_EN.
module strfmt_scheduler
  import strfmt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*2-1:0]    req_radix,
  input  logic [NREQ*32-1:0]   req_value,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_char,
  output logic                 out_last,
  output logic [ID_W-1:0]      out_id,
  output logic                 out_err
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q;
  logic [32:0]     work_q;
  radix_e          radix_q;
  logic            neg_q, minus_q;
  logic [5:0]      len_q, idx_q;
  logic [7:0]      char_buf_q [BUF_DEPTH];
  logic            out_valid_q, out_last_q, out_err_q;
  logic [7:0]      out_char_q;
  logic [ID_W-1:0] out_id_q;

  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_any, accept, dec_unsup;
  logic [1:0]      sel_radix;
  logic [31:0]     sel_value;
  logic [3:0]      digit;
  logic [32:0]     work_next;
  logic [7:0]      conv_char;
  logic            conv_done;
  logic [5:0]      idx_m1;

  strfmt_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_any)
  );

  always_comb begin
    sel_radix = '0;
    sel_value = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_radix = req_radix[i*2 +: 2];
        sel_value = req_value[i*32 +: 32];
      end
    end
  end

`ifdef STRFMT_DEC_EN
  assign dec_unsup = 1'b0;
`else
  assign dec_unsup = (radix_e'(sel_radix) == RADIX_DEC);
`endif

  assign accept = (state_q == ST_IDLE) && gnt_any && !rst;

  // One digit per cycle from the working value, least significant first.
  always_comb begin
    digit     = '0;
    work_next = '0;
    case (radix_q)
      RADIX_HEX: begin
        digit     = work_q[3:0];
        work_next = work_q >> 4;
      end
      RADIX_OCT: begin
        digit     = {1'b0, work_q[2:0]};
        work_next = work_q >> 3;
      end
      RADIX_DEC: begin
`ifdef STRFMT_DEC_EN
        digit     = 4'(work_q % 33'd10);
        work_next = work_q / 33'd10;
`endif
      end
      default: begin
        digit     = {3'b000, work_q[0]};
        work_next = work_q >> 1;
      end
    endcase
    conv_char = minus_q ? ASCII_MINUS : digit_char(digit);
    conv_done = minus_q || ((work_next == '0) && !neg_q);
  end

  assign idx_m1 = idx_q - 6'd1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = dec_unsup ? ST_EMIT : ST_CONV;
      ST_CONV: if (conv_done) state_d = ST_EMIT;
      ST_EMIT: if (out_valid_q && out_ready && out_last_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = accept ? gnt : '0;
    out_valid = out_valid_q;
    out_char  = out_char_q;
    out_last  = out_last_q;
    out_id    = out_id_q;
    out_err   = out_err_q;
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_CONV) char_buf_q[len_q] <= conv_char;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      work_q      <= '0;
      radix_q     <= RADIX_DEC;
      neg_q       <= 1'b0;
      minus_q     <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rr_ptr_q <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            out_id_q <= gnt_idx;
            radix_q  <= radix_e'(sel_radix);
            minus_q  <= 1'b0;
            len_q    <= '0;
`ifdef STRFMT_DEC_EN
            // Magnitude is kept in 33 bits so -2^31 negates cleanly.
            if ((radix_e'(sel_radix) == RADIX_DEC) && sel_value[31]) begin
              neg_q  <= 1'b1;
              work_q <= {1'b0, ~sel_value} + 33'd1;
            end else begin
              neg_q  <= 1'b0;
              work_q <= {1'b0, sel_value};
            end
`else
            neg_q  <= 1'b0;
            work_q <= {1'b0, sel_value};
`endif
            if (dec_unsup) begin
              out_valid_q <= 1'b1;
              out_char_q  <= ASCII_QMARK;
              out_last_q  <= 1'b1;
              out_err_q   <= 1'b1;
              len_q       <= 6'd1;
              idx_q       <= '0;
            end else begin
              out_err_q <= 1'b0;
            end
          end
        end
        ST_CONV: begin
          len_q  <= len_q + 6'd1;
          work_q <= work_next;
          if (!minus_q && (work_next == '0) && neg_q) minus_q <= 1'b1;
          // The character produced on the final cycle is the most significant one.
          if (conv_done) begin
            out_valid_q <= 1'b1;
            out_char_q  <= conv_char;
            out_last_q  <= (len_q == '0);
            idx_q       <= len_q;
          end
        end
        ST_EMIT: begin
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_err_q   <= 1'b0;
            end else begin
              idx_q      <= idx_m1;
              out_char_q <= char_buf_q[idx_m1];
              out_last_q <= (idx_q == 6'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_strfmt_scheduler.sv
// tb/tb_strfmt_scheduler.sv - directed and randomized checks of strfmt_scheduler against a string model
module tb_strfmt_scheduler;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*2-1:0]   req_radix;
  logic [NREQ*32-1:0]  req_value;
  logic [NREQ-1:0]     req_ready;
  logic                out_valid, out_ready, out_last, out_err;
  logic [7:0]          out_char;
  logic [ID_W-1:0]     out_id;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  strfmt_scheduler #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_radix (req_radix),
    .req_value (req_value),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_last  (out_last),
    .out_id    (out_id),
    .out_err   (out_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic string model(input logic [1:0] r, input logic [31:0] v, output bit err);
    err = 1'b0;
    case (r)
      2'b00: begin
`ifdef STRFMT_DEC_EN
        return $sformatf("%0d", $signed(v));
`else
        err = 1'b1;
        return "?";
`endif
      end
      2'b01:   return $sformatf("%0h", v);
      2'b10:   return $sformatf("%0o", v);
      default: return $sformatf("%0b", v);
    endcase
  endfunction

  // Called in the accept cycle (k=0); follows the string to its last handshake.
  task automatic collect(input int id, input string s, input bit err, input int stall_pct, input string tag);
    int n, k, got, exp_first;
    bit seen, held, done;
    logic [7:0] h_char;
    logic h_last, h_err;
    logic [ID_W-1:0] h_id;
    n = s.len(); k = 0; got = 0; seen = 0; held = 0; done = 0;
    h_char = '0; h_last = 0; h_err = 0; h_id = '0;
    exp_first = err ? 1 : n + 1;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
      if (k == 1) req_valid[id] = 1'b0;
      out_ready = ($urandom_range(99) >= stall_pct);
      #1;
      if (held) begin
        chk({tag, " hold"}, {out_valid, out_char, out_last, out_id, out_err},
            {1'b1, h_char, h_last, h_id, h_err});
        held = 0;
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          chk({tag, " first_cycle"}, k, exp_first);
        end
        chk({tag, " char"}, out_char, s[got]);
        chk({tag, " last"}, out_last, (got == n - 1));
        chk({tag, " id"}, out_id, id);
        chk({tag, " err"}, out_err, err);
        if (out_ready) begin
          if (got == n - 1) begin
            done = 1;
            if (stall_pct == 0) chk({tag, " last_cycle"}, k, exp_first + n - 1);
          end
          got++;
        end else begin
          held = 1;
          h_char = out_char; h_last = out_last; h_id = out_id; h_err = out_err;
        end
      end
    end
    chk({tag, " completed"}, done, 1'b1);
    chk({tag, " count"}, got, n);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk({tag, " idle_after"}, out_valid, 1'b0);
  endtask

  task automatic single(input int id, input logic [1:0] r, input logic [31:0] v, input int stall_pct, input string tag);
    string s;
    bit err;
    int w;
    logic [NREQ-1:0] eg;
    s = model(r, v, err);
    eg = '0;
    eg[id] = 1'b1;
    w = 0;
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_radix[id*2 +: 2] = r;
    req_value[id*32 +: 32] = v;
    out_ready = 1'b1;
    #1;
    while (req_ready !== eg && w < 100) begin
      @(negedge clk);
      w++;
      #1;
    end
    chk({tag, " grant"}, req_ready, eg);
    collect(id, s, err, stall_pct, tag);
  endtask

  initial begin
    logic [31:0] vals [NREQ];
    logic [1:0]  rads [NREQ];
    logic [NREQ-1:0] eg;
    string s;
    bit err;
    int gcount, scount, cur, pos, cyc, w, got;

    rst = 1'b1;
    req_valid = '1;
    req_radix = '0;
    req_value = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst req_ready", req_ready, '0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_char", out_char, 8'h00);
    chk("rst out_last", out_last, 1'b0);
    chk("rst out_id", out_id, '0);
    chk("rst out_err", out_err, 1'b0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    single(0, 2'b00, 32'd0,          0,  "dec_zero");
    single(1, 2'b00, 32'h80000000,   0,  "dec_min");
    single(2, 2'b00, 32'd1234567,    20, "dec_pos");
    single(3, 2'b01, 32'h00DEAD0F,   0,  "hex");
    single(0, 2'b10, 32'o17,         0,  "oct");
    single(1, 2'b11, 32'h5,          0,  "bin");
    single(2, 2'b01, 32'h0,          0,  "hex_zero");
    single(3, 2'b11, 32'hFFFFFFFF,   40, "bin_stall");
    single(0, 2'b11, 32'hFFFFFFFF,   0,  "bin_worst");

    // Round-robin: all requesters valid from a fresh pointer.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rads[i] = 2'($urandom_range(3));
      vals[i] = $urandom >> $urandom_range(31);
      req_radix[i*2 +: 2] = rads[i];
      req_value[i*32 +: 32] = vals[i];
    end
    req_valid = '1;
    out_ready = 1'b1;
    gcount = 0; scount = 0; cur = 0; pos = 0; cyc = 0;
    s = "";
    err = 0;
    w = 0;
    while (scount < 5 && cyc < 1000) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      #1;
      if (req_ready != '0) begin
        eg = '0;
        eg[gcount % NREQ] = 1'b1;
        chk("rr grant", req_ready, eg);
        chk("rr busy", w, 0);
        w = 1;
        cur = gcount % NREQ;
        gcount++;
        s = model(rads[cur], vals[cur], err);
        pos = 0;
      end
      if (out_valid) begin
        chk("rr char", out_char, s[pos]);
        chk("rr id", out_id, cur);
        chk("rr last", out_last, (pos == s.len() - 1));
        if (out_last) begin
          w = 0;
          scount++;
        end
        pos++;
      end
    end
    chk("rr strings", scount, 5);
    @(negedge clk);
    req_valid = '0;

    for (int t = 0; t < 16; t++) begin
      int id;
      logic [1:0] r;
      logic [31:0] v;
      id = $urandom_range(NREQ - 1);
      r = 2'($urandom_range(3));
      v = $urandom >> $urandom_range(31);
      single(id, r, v, ($urandom_range(1) == 1) ? 30 : 0, $sformatf("rand%0d", t));
    end

    // Reset while mid-EMIT of a long binary string.
    @(negedge clk);
    req_radix[2*2 +: 2] = 2'b11;
    req_value[2*32 +: 32] = 32'hFFFFFFFF;
    req_radix[1*2 +: 2] = 2'b01;
    req_value[1*32 +: 32] = 32'h00000ABC;
    req_radix[3*2 +: 2] = 2'b10;
    req_value[3*32 +: 32] = 32'o755;
    req_valid[2] = 1'b1;
    out_ready = 1'b1;
    w = 0;
    #1;
    while (req_ready[2] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
      #1;
    end
    chk("mid grant", req_ready[2], 1'b1);
    w = 0;
    got = 0;
    while (got < 3 && w < 200) begin
      @(negedge clk);
      w++;
      if (w == 1) req_valid[2] = 1'b0;
      #1;
      if (out_valid) got++;
    end
    chk("mid chars", got, 3);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b1010;
    #1;
    chk("mid rst req_ready", req_ready, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid out_valid", out_valid, 1'b0);
    chk("mid out_last", out_last, 1'b0);
    chk("mid out_char", out_char, 8'h00);
    chk("mid regrant", req_ready, 4'b0010);
    req_valid[3] = 1'b0;
    s = model(2'b01, 32'h00000ABC, err);
    collect(1, s, err, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/strfmt_scheduler.md
# strfmt_scheduler

Shared number-to-text conversion engine with arbitration. Up to NREQ requesters submit a 32-bit value plus a radix code. A round-robin arbiter grants one request at a time. The block converts the value digit by digit, using the same formatting rules as the string `itoa`/`hextoa`/`octtoa`/`bintoa` methods, and streams the ASCII result out MSB-first over a valid/ready byte channel. It sits between the formatting clients and the string-assembly/log sink.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- ID_W, $clog2(NREQ), width of the requester ID

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request
- req_radix  in  NREQ×2  radix code: 00 dec (signed), 01 hex, 10 oct, 11 bin
- req_value  in  NREQ×32  value to convert
- req_ready  out  NREQ  one-hot accept pulse; the request is taken when valid&ready
- out_valid  out  1  character valid
- out_ready  in  1  sink ready
- out_char  out  8  ASCII character
- out_last  out  1  marks the final character of the string
- out_id  out  ID_W  ID of the requester that owns the current string
- out_err  out  1  unsupported radix (see Configuration); held for the whole string

## Operation
- FSM states: IDLE → CONV → EMIT → IDLE.
- IDLE
  - If any req_valid is set, grant the first set index at or after rr_ptr, searching cyclically.
  - Assert req_ready[g] combinationally in that cycle.
  - Capture value, radix and g. Set rr_ptr = (g+1) mod NREQ. Go to CONV.
- CONV: produces one digit per cycle, LSB first, into a 33-entry character buffer.
  - hex: nibble per digit, lowercase 'a'–'f'. oct: 3 bits per digit. bin: 1 bit per digit. Logical right shift after each digit.
  - dec:
    - Treat the value as signed.
    - If negative, convert the magnitude. Compute it in 33 bits so that -2147483648 works.
    - Each cycle: digit = mag % 10, mag = mag / 10.
    - After the last digit, append '-' in one extra cycle.
  - Stop when the working value reaches 0 after at least one digit. A value of 0 therefore yields exactly "0".
  - No leading zeros in any radix.
  - Go to EMIT with len = number of buffered characters.
- EMIT
  - Present buffer[len-1] down to buffer[0].
  - Advance only when out_valid&out_ready.
  - out_last = 1 on buffer[0]. On the out_last handshake, go to IDLE.
- req_ready is 0 outside IDLE. Pending requests stay asserted by their requesters. Requesters must hold radix and value stable while valid.
- Reset values: state IDLE, rr_ptr 0, req_ready 0, out_valid 0, out_char 0, out_last 0, out_id 0, out_err 0, len 0.
- Reset in mid-CONV or mid-EMIT aborts the string immediately. No out_last is produced. out_valid is 0 the next cycle.

## Timing
- Accept handshake in cycle t.
- Digit generation runs from t+1 to t+D, where D = digit count (+1 for '-').
- First out_valid in cycle t+D+1.
- With out_ready held high, one character per cycle. The last character is at t+2D.
- The next grant is possible in the cycle after the out_last handshake.
- Worst case with no stall: bin 0xFFFFFFFF → D=32, so 65 cycles from accept to IDLE.
- out_char, out_last, out_id and out_err are registered and stable while out_valid && !out_ready.
- Simultaneous requests in IDLE: exactly one grant per cycle, round-robin order.

## Configuration
- STRFMT_DEC_EN defined: decimal radix is supported, including the divide/modulo-by-10 and sign logic.
- STRFMT_DEC_EN undefined: radix 00 is accepted but not converted. The request skips CONV (D=0) and emits a single '?' (0x3F) with out_last=1 and out_err=1. The first out_valid comes at t+1.
- out_err is 0 for every other case.

## Structure
- Package strfmt_pkg: radix enum (RADIX_DEC/HEX/OCT/BIN), FSM state enum, BUF_DEPTH=33, and the ASCII constants '0', 'a', '-', '?'.
- One sub-module, strfmt_rr_arb (NREQ): round-robin grant from req_valid and rr_ptr, one-hot grant plus encoded index. It is purely combinational; the pointer register lives in the parent.

## Test plan
- Single requester: dec value 0 → "0" (0x30), out_last on the first character, first out_valid at t+2.
- Dec -2147483648 (32'h80000000) → "-2147483648": 11 characters, '-' first, out_id = requester.
- Hex 32'h00DEAD0F → "dead0f"; oct 32'o17 → "17"; bin 32'h5 → "101". All lowercase, no leading zeros.
- All four requesters valid continuously, out_ready=1 → grants in order 0,1,2,3,0. Each string completes before the next req_ready pulse.
- Random out_ready stalls during bin 0xFFFFFFFF → 32 '1' characters, outputs stable while stalled, exactly one out_last.
- rst pulsed mid-EMIT → out_valid=0 next cycle, rr_ptr=0, the next grant goes to the lowest valid index. With STRFMT_DEC_EN undefined: dec request → single '?' with out_err=1.
